// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, configurable frame format and
// back-to-back frames; all outputs come straight from flops.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   input  logic [DATA_BITS-1:0]          s_data,
   output logic                          s_ready,
   output logic                          tx_out,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int DIV   = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic                 push, pop, bit_end;
   logic [DATA_BITS-1:0] head;

   assign s_ready    = (count_q < CW'(FIFO_DEPTH));
   assign push       = s_valid && s_ready;
   assign head       = mem_q[rd_q];
   assign bit_end    = (baud_q == CNT_W'(DIV - 1));
   assign tx_out     = tx_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      pop     = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The frame's word and its parity are frozen at pop time.
      if (pop) begin
         shreg_d = head;
         par_d   = (PARITY == 1) ? ~(^head) : ^head;
      end

      rd_d    = pop  ? rd_q + 1'b1 : rd_q;
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      count_d = count_q + CW'(push) - CW'(pop);

      // Line and status flops follow the state one cycle later, so every
      // line bit still lasts exactly DIV cycles.
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_q[0];
         PAR:     tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      if (push) mem_q[wr_q] <= s_data;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five instances cover 8N1, 7E1, 7O1, 8N2
// back-to-back/full-FIFO and 5N1 framing, plus asynchronous reset mid-frame.
module tb_uart_tx_fifo;

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      sv;
   logic [7:0]      d0, d3;
   logic [6:0]      d1, d2;
   logic [4:0]      d4;
   logic [4:0]      rdy_v, tx_v, busy_v, done_v;
   logic [4:0][2:0] cnt_v;
   int              checks   = 0;
   int              failures = 0;
   logic [7:0]      wl [6];
   logic [63:0]     ln, dn;
   int              w;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .s_valid(sv[0]), .s_data(d0), .s_ready(rdy_v[0]),
      .tx_out(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_count(cnt_v[0]));
   uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(250000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst), .s_valid(sv[1]), .s_data(d1), .s_ready(rdy_v[1]),
      .tx_out(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_count(cnt_v[1]));
   uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(250000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst(rst), .s_valid(sv[2]), .s_data(d2), .s_ready(rdy_v[2]),
      .tx_out(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_count(cnt_v[2]));
   uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .rst(rst), .s_valid(sv[3]), .s_data(d3), .s_ready(rdy_v[3]),
      .tx_out(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_count(cnt_v[3]));
   uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(250000), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
      .clk(clk), .rst(rst), .s_valid(sv[4]), .s_data(d4), .s_ready(rdy_v[4]),
      .tx_out(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]), .fifo_count(cnt_v[4]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each frame bit (index 0 = first on the line) repeated for DIV=4 cycles.
   function automatic logic [63:0] expand(input logic [15:0] bits, input int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 4; j++)
            r[i*4+j] = bits[i];
      return r;
   endfunction

   task automatic set_data(input int k, input logic [7:0] v);
      case (k)
         0:       d0 = v;
         1:       d1 = v[6:0];
         2:       d2 = v[6:0];
         3:       d3 = v;
         default: d4 = v[4:0];
      endcase
   endtask

   task automatic push(input int k, input logic [7:0] v);
      set_data(k, v);
      sv[k] = 1'b1;
      @(negedge clk);
      sv[k] = 1'b0;
      set_data(k, ~v);
   endtask

   task automatic capture(input int k, input int len, output logic [63:0] l,
                          output logic [63:0] d, output int wt);
      l  = '0;
      d  = '0;
      wt = 0;
      while (tx_v[k] !== 1'b0 && wt < 400) begin
         @(negedge clk);
         wt++;
      end
      chk("start_timeout", 64'(wt < 400), 64'd1);
      for (int c = 0; c < len; c++) begin
         l[c] = tx_v[k];
         d[c] = done_v[k];
         @(negedge clk);
      end
   endtask

   initial begin
      wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h3C;
      wl[3] = 8'hC3; wl[4] = 8'h5A; wl[5] = 8'hFF;
      sv = '0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx",    64'(tx_v),   64'h1f);
      chk("rst_busy",  64'(busy_v), 64'h0);
      chk("rst_done",  64'(done_v), 64'h0);
      chk("rst_ready", 64'(rdy_v),  64'h1f);
      chk("rst_count", 64'(cnt_v),  64'h0);
      rst = 1'b1;
      @(negedge clk);

      // 8N1 0xA5: latency, line pattern, tx_done position, busy release
      push(0, 8'hA5);
      chk("lat_tx_e0",   64'(tx_v[0]),   64'd1);
      chk("lat_cnt_e0",  64'(cnt_v[0]),  64'd1);
      chk("lat_busy_e0", 64'(busy_v[0]), 64'd0);
      @(negedge clk);
      chk("lat_tx_e1",   64'(tx_v[0]),   64'd1);
      chk("lat_cnt_e1",  64'(cnt_v[0]),  64'd0);
      @(negedge clk);
      chk("lat_tx_e2",   64'(tx_v[0]),   64'd0);
      chk("lat_busy_e2", 64'(busy_v[0]), 64'd1);
      capture(0, 40, ln, dn, w);
      chk("lat_wait",   64'(w), 64'd0);
      chk("frame_a5",   ln, expand(16'h034A, 10));
      chk("done_a5",    dn, 64'h0000_0080_0000_0000);
      chk("busy_after", 64'(busy_v[0]), 64'd0);
      chk("idle_after", 64'(tx_v[0]),   64'd1);

      // 7E1 and 7O1 with 0x03
      push(1, 8'h03);
      capture(1, 40, ln, dn, w);
      chk("frame_7e1", ln, expand(16'h0206, 10));
      chk("done_7e1",  dn, 64'h0000_0080_0000_0000);
      push(2, 8'h03);
      capture(2, 40, ln, dn, w);
      chk("frame_7o1", ln, expand(16'h0306, 10));
      chk("done_7o1",  dn, 64'h0000_0080_0000_0000);

      // 5N1 with 0x3F: only five ones, 28-cycle frame
      push(4, 8'h3F);
      capture(4, 28, ln, dn, w);
      chk("frame_5n1", ln, expand(16'h007E, 7));
      chk("done_5n1",  dn, 64'h0000_0000_0800_0000);
      chk("busy_5n1",  64'(busy_v[4]), 64'd0);

      // 8N2: six words held on s_valid, back-to-back frames, full-FIFO pop
      fork
         begin : pusher
            int   i, cyc, full_seen;
            logic acc, popped;
            logic [2:0] prev;
            i = 0; cyc = 0; full_seen = 0; popped = 1'b0;
            while (i < 6 && cyc < 2000) begin
               d3    = wl[i];
               sv[3] = 1'b1;
               if (cnt_v[3] == 3'd4) begin
                  full_seen++;
                  chk("ready_full", 64'(rdy_v[3]), 64'd0);
               end else begin
                  chk("ready_notfull", 64'(rdy_v[3]), 64'd1);
               end
               acc  = rdy_v[3];
               prev = cnt_v[3];
               @(negedge clk);
               cyc++;
               if (popped) chk("push_after_pop", 64'(cnt_v[3]), 64'd4);
               popped = (prev == 3'd4) && done_v[3];
               if (popped) chk("full_pop_count", 64'(cnt_v[3]), 64'd3);
               if (acc) i++;
            end
            sv[3] = 1'b0;
            d3    = 8'h00;
            chk("push_all",  64'(i), 64'd6);
            chk("full_seen", 64'(full_seen > 0), 64'd1);
         end
         begin : receiver
            logic [63:0] fl, fd;
            int          fw;
            logic [7:0]  rb;
            for (int f = 0; f < 6; f++) begin
               capture(3, 44, fl, fd, fw);
               for (int b = 0; b < 8; b++) rb[b] = fl[4*(b+1)+1];
               if (f > 0) chk("b2b_gap", 64'(fw), 64'd0);
               chk("b2b_frame", fl, expand({5'b0, 2'b11, wl[f], 1'b0}, 11));
               chk("b2b_done",  fd, 64'h0000_0800_0000_0000);
               chk("b2b_byte",  64'(rb), 64'(wl[f]));
            end
            chk("b2b_idle", 64'(tx_v[3]), 64'd1);
         end
      join

      // async reset mid-DATA with two words queued
      push(0, 8'hA5);
      push(0, 8'h12);
      push(0, 8'h34);
      repeat (9) @(negedge clk);
      chk("pre_rst_tx",   64'(tx_v[0]),   64'd0);
      chk("pre_rst_cnt",  64'(cnt_v[0]),  64'd2);
      chk("pre_rst_busy", 64'(busy_v[0]), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_tx",    64'(tx_v[0]),   64'd1);
      chk("async_busy",  64'(busy_v[0]), 64'd0);
      chk("async_cnt",   64'(cnt_v[0]),  64'd0);
      chk("async_ready", 64'(rdy_v[0]),  64'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      begin
         int bad_tx, bad_done, bad_busy;
         bad_tx = 0; bad_done = 0; bad_busy = 0;
         for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1)   bad_tx++;
            if (done_v[0] !== 1'b0) bad_done++;
            if (busy_v[0] !== 1'b0) bad_busy++;
         end
         chk("post_rst_tx",   64'(bad_tx),   64'd0);
         chk("post_rst_done", 64'(bad_done), 64'd0);
         chk("post_rst_busy", 64'(bad_busy), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
